timer_slot_sched: RTL

- Controller that shares one TIMER output-up window among N_REQ requesters.
- Drives the TIMER enable and sequences cold boot.
- Selects one owner per TIMER frame, round-robin, and gates that owner's grant with the TIMER window output.
- Sits between the requesting datapath lanes and a single TIMER instance; powers the TIMER down when no one is requesting.

---
 rtl/timer_slot_sched_pkg.sv | 17 +
 rtl/timer_slot_sched_if.sv | 30 +++
 rtl/timer_slot_sched_rr_picker.sv | 38 +++
 rtl/timer_slot_sched.sv | 126 ++++++++++++
 4 files changed

// File: rtl/timer_slot_sched_pkg.sv
// Shared types and constants for the TIMER slot scheduler.
package timer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BOOT = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int TIMER_CNT_W = 5;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_slot_sched_if.sv
// Requester / TIMER side bundle of the slot scheduler.
interface timer_slot_sched_if
  import timer_sched_pkg::*;
#(
  parameter int N_REQ = 4
);
  localparam int ID_W = idx_w(N_REQ);

  logic [N_REQ-1:0]       req;
  logic                   timer_o;
  logic [TIMER_CNT_W-1:0] timer_valid_count;
  logic                   timer_en;
  logic [N_REQ-1:0]       grant;
  logic [ID_W-1:0]        grant_id;
  logic                   owner_vld;
  logic                   frame_done;
  logic                   boot_err;
  logic                   busy;

  modport master (
    output req, timer_o, timer_valid_count,
    input  timer_en, grant, grant_id, owner_vld, frame_done, boot_err, busy
  );

  modport slave (
    input  req, timer_o, timer_valid_count,
    output timer_en, grant, grant_id, owner_vld, frame_done, boot_err, busy
  );

endinterface

// File: rtl/timer_slot_sched_rr_picker.sv
// Combinational round-robin pick: first requester after i_last_owner, wrapping.
module rr_picker
  import timer_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int ID_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_last_owner,
  output logic [ID_W-1:0]  o_pick,
  output logic             o_any_req
);
  localparam logic [ID_W:0] N_L = (ID_W+1)'(N_REQ);

  logic [2*N_REQ-1:0] w_req2;
  logic [N_REQ-1:0]   w_rot;
  logic [ID_W:0]      w_shamt;
  logic [ID_W:0]      w_pos;
  logic [ID_W:0]      w_sum;

  // Rotating the doubled vector puts requester last_owner+1 at bit 0.
  assign w_req2    = {i_req, i_req};
  assign w_shamt   = {1'b0, i_last_owner} + {{ID_W{1'b0}}, 1'b1};
  assign w_rot     = N_REQ'(w_req2 >> w_shamt);
  assign o_any_req = |i_req;

  // Lowest set bit of the rotated vector
  always_comb begin
    w_pos = {(ID_W+1){1'b0}};
    for (int j = N_REQ - 1; j >= 0; j--) begin
      w_pos = w_rot[j] ? (ID_W+1)'(j) : w_pos;
    end
  end

  assign w_sum  = w_shamt + w_pos;
  assign o_pick = (w_sum >= N_L) ? ID_W'(w_sum - N_L) : ID_W'(w_sum);

endmodule

// File: rtl/timer_slot_sched.sv
// Shares one TIMER output window among N_REQ requesters: powers the TIMER,
// supervises its cold boot and hands each frame to one owner round-robin.
module timer_slot_sched
  import timer_sched_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int COLD_BOOT_CYCLE = 20,
  parameter int FULL_CYCLE      = 23,
  parameter int BOOT_TIMEOUT    = 28
) (
  input logic               clk,
  input logic               rst,
  timer_slot_sched_if.slave bus
);
  localparam int ID_W = idx_w(N_REQ);
  localparam int BC_W = $clog2(((BOOT_TIMEOUT > COLD_BOOT_CYCLE) ?
                                BOOT_TIMEOUT : COLD_BOOT_CYCLE) + 1);
  localparam logic [BC_W-1:0]        BC_TMO   = BC_W'(BOOT_TIMEOUT);
  localparam logic [BC_W-1:0]        BC_MAX   = {BC_W{1'b1}};
  localparam logic [TIMER_CNT_W-1:0] CNT_FULL = TIMER_CNT_W'(FULL_CYCLE);
  localparam logic [ID_W-1:0]        LAST_RST = ID_W'(N_REQ - 1);

  state_e          r_state, w_state_nxt;
  logic [ID_W-1:0] r_owner, w_owner_nxt;
  logic [ID_W-1:0] r_last_owner, w_last_owner_nxt;
  logic            r_owner_vld, w_owner_vld_nxt;
  logic            r_timer_en, w_timer_en_nxt;
  logic [BC_W-1:0] r_boot_cnt, w_boot_cnt_nxt;

  logic [ID_W-1:0]  w_pick;
  logic             w_any_req;
  logic             w_frame_end;
  logic             w_boot_to;
  logic             w_live;
  logic [N_REQ-1:0] w_owner_oh;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .i_req        (bus.req),
    .i_last_owner (r_last_owner),
    .o_pick       (w_pick),
    .o_any_req    (w_any_req)
  );

  assign w_frame_end = (r_state == RUN) && (bus.timer_valid_count == CNT_FULL);
  assign w_boot_to   = (r_state == BOOT) && !bus.timer_o && (r_boot_cnt == BC_TMO);

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_owner_vld_nxt  = r_owner_vld;
    w_boot_cnt_nxt   = r_boot_cnt;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt      = BOOT;
          w_owner_nxt      = w_pick;
          w_last_owner_nxt = w_pick;
          w_owner_vld_nxt  = 1'b1;
          w_boot_cnt_nxt   = {BC_W{1'b0}};
        end else begin
          w_owner_vld_nxt  = 1'b0;
        end
      end
      BOOT: begin
        w_boot_cnt_nxt = (r_boot_cnt == BC_MAX) ? r_boot_cnt : r_boot_cnt + BC_W'(1);
        if (bus.timer_o) begin
          w_state_nxt = RUN;
        end else if (w_boot_to) begin
          // Dropping to IDLE pulls timer_en low for a cycle, restarting the cold boot.
          w_state_nxt     = IDLE;
          w_owner_vld_nxt = 1'b0;
        end else begin
          w_state_nxt = BOOT;
        end
      end
      RUN: begin
        if (w_frame_end && w_any_req) begin
          w_owner_nxt      = w_pick;
          w_last_owner_nxt = w_pick;
        end else if (w_frame_end) begin
          w_state_nxt     = IDLE;
          w_owner_vld_nxt = 1'b0;
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_owner_vld_nxt = 1'b0;
      end
    endcase
    w_timer_en_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_owner      <= {ID_W{1'b0}};
      r_last_owner <= LAST_RST;
      r_owner_vld  <= 1'b0;
      r_timer_en   <= 1'b0;
      r_boot_cnt   <= {BC_W{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_owner_vld  <= w_owner_vld_nxt;
      r_timer_en   <= w_timer_en_nxt;
      r_boot_cnt   <= w_boot_cnt_nxt;
    end
  end

  // Grant follows timer_o combinationally so it is live on the first window cycle.
  assign w_live     = r_owner_vld && ((r_state == BOOT) || (r_state == RUN));
  assign w_owner_oh = N_REQ'(1'b1) << r_owner;

  assign bus.grant      = (w_live && bus.timer_o) ? w_owner_oh : {N_REQ{1'b0}};
  assign bus.grant_id   = r_owner;
  assign bus.owner_vld  = r_owner_vld;
  assign bus.timer_en   = r_timer_en;
  assign bus.frame_done = w_frame_end;
  assign bus.boot_err   = w_boot_to;
  assign bus.busy       = (r_state != IDLE);

endmodule
